// File: rtl/disp_pkg.sv
// Shared definitions for the display scan multiplexer: mode encodings,
// FSM state type and the index-width helper used to size index/counter buses.
// No ports; imported by disp_scan_mux and usable by word_mux_n clients.
package disp_pkg;

    localparam logic MODE_AUTO   = 1'b0;
    localparam logic MODE_MANUAL = 1'b1;

    // GAP is only ever entered when the blanking feature is compiled in.
    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } state_t;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/word_mux_n.sv
// N:1 selector of W-bit words packed into one flat bus (word k at [k*W +: W]).
// Ports: data_in (N*W), sel (IW) -> y (W). Purely combinational, zero latency.
// An out-of-range sel yields all-zero.
module word_mux_n #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N*W-1:0] data_in,
    input  logic [IW-1:0]  sel,
    output logic [W-1:0]   y
);

    always_comb begin
        y = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == IW'(k)) begin
                y = data_in[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/disp_scan_mux.sv
// Multiplexed display scanner: shows one of N W-bit channels at a time, either
// auto-scanning with a DWELL-cycle dwell per channel (hold freezes it) or
// manually selected by sel_in (clamped to N-1). All outputs are registered.
// Ports: clk, reset (sync, active-high), data_in[N*W], mode, sel_in[IW], hold
//        -> out[W], chan_en[N] (one-hot or zero), chan_idx[IW], valid.
// Optional macro DISP_SCAN_MUX_BLANK_EN inserts BLANK blank cycles (GAP state)
// on every index change; without it the index switches directly.
module disp_scan_mux
    import disp_pkg::*;
#(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int DWELL = 1000,
    parameter int BLANK = 2,
    localparam int IW   = idx_width(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N*W-1:0] data_in,
    input  logic           mode,
    input  logic [IW-1:0]  sel_in,
    input  logic           hold,
    output logic [W-1:0]   out,
    output logic [N-1:0]   chan_en,
    output logic [IW-1:0]  chan_idx,
    output logic           valid
);

    localparam int             CW       = idx_width(DWELL);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DWELL - 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(N - 1);

    // An illegal configuration shows up as this named block in the hierarchy.
    generate
        if (W < 1 || N < 2 || DWELL < 1 || BLANK < 1) begin : g_bad_params
        end
    endgenerate

    state_t          state_q, state_d;
    logic [IW-1:0]   chan_idx_q, chan_idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // Set when the cycle on the outputs is part of an ongoing auto dwell; when
    // clear, the next auto cycle starts a fresh dwell at count 0.
    logic            auto_q, auto_d;
    logic [W-1:0]    out_q, out_d;
    logic [N-1:0]    chan_en_q, chan_en_d;
    logic            valid_q, valid_d;

    logic [IW-1:0]   sel_clamped;
    logic [IW-1:0]   idx_next_auto;
    logic [IW-1:0]   target;
    logic            change;
    logic [W-1:0]    mux_y;

`ifdef DISP_SCAN_MUX_BLANK_EN
    localparam int            GW       = idx_width(BLANK);
    localparam logic [GW-1:0] GAP_LAST = GW'(BLANK - 1);
    logic [IW-1:0]  pend_q, pend_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
`endif

    assign sel_clamped   = ({1'b0, sel_in} > {1'b0, IDX_LAST}) ? IDX_LAST : sel_in;
    assign idx_next_auto = (chan_idx_q == IDX_LAST) ? '0 : chan_idx_q + 1'b1;

    // Selector runs on the next index so out/chan_en line up with chan_idx.
    word_mux_n #(
        .W  (W),
        .N  (N),
        .IW (IW)
    ) u_word_mux (
        .data_in (data_in),
        .sel     (chan_idx_d),
        .y       (mux_y)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SHOW;
            chan_idx_q <= '0;
            cnt_q      <= '0;
            auto_q     <= 1'b0;
            out_q      <= '0;
            chan_en_q  <= '0;
            valid_q    <= 1'b0;
`ifdef DISP_SCAN_MUX_BLANK_EN
            pend_q     <= '0;
            gap_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            chan_idx_q <= chan_idx_d;
            cnt_q      <= cnt_d;
            auto_q     <= auto_d;
            out_q      <= out_d;
            chan_en_q  <= chan_en_d;
            valid_q    <= valid_d;
`ifdef DISP_SCAN_MUX_BLANK_EN
            pend_q     <= pend_d;
            gap_cnt_q  <= gap_cnt_d;
`endif
        end
    end

    // Next-state logic: index, dwell counter and SHOW/GAP sequencing
    always_comb begin
        state_d    = state_q;
        chan_idx_d = chan_idx_q;
        cnt_d      = cnt_q;
        auto_d     = 1'b0;
        target     = chan_idx_q;
        change     = 1'b0;
`ifdef DISP_SCAN_MUX_BLANK_EN
        pend_d     = pend_q;
        gap_cnt_d  = gap_cnt_q;
`endif
        case (state_q)
            SHOW: begin
                if (mode == MODE_MANUAL) begin
                    cnt_d  = '0;
                    target = sel_clamped;
                    change = (sel_clamped != chan_idx_q);
                end else begin
                    auto_d = 1'b1;
                    if (!auto_q) begin
                        cnt_d = '0;
                    end else if (hold) begin
                        cnt_d = cnt_q;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        target = idx_next_auto;
                        change = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef DISP_SCAN_MUX_BLANK_EN
                if (change) begin
                    state_d   = GAP;
                    pend_d    = target;
                    gap_cnt_d = '0;
                    cnt_d     = '0;
                    auto_d    = 1'b0;
                end
`else
                if (change) begin
                    chan_idx_d = target;
                end
`endif
            end
`ifdef DISP_SCAN_MUX_BLANK_EN
            GAP: begin
                cnt_d = '0;
                // Manual selection keeps retargeting; the blank count runs on.
                if (mode == MODE_MANUAL) begin
                    pend_d = sel_clamped;
                end
                if (gap_cnt_q == GAP_LAST) begin
                    state_d    = SHOW;
                    chan_idx_d = pend_d;
                    // The exit cycle is dwell position 0 of the new channel.
                    auto_d     = (mode == MODE_AUTO);
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = SHOW;
            end
        endcase
    end

    // Output logic: registered view of the next cycle
    always_comb begin
        valid_d   = (state_d == SHOW);
        out_d     = valid_d ? mux_y : '0;
        chan_en_d = '0;
        for (int k = 0; k < N; k++) begin
            chan_en_d[k] = valid_d && (chan_idx_d == IW'(k));
        end
    end

    assign out      = out_q;
    assign chan_en  = chan_en_q;
    assign chan_idx = chan_idx_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Scoreboard bench for disp_scan_mux (N=4 and N=3 instances, W=8, DWELL=3, BLANK=2).
// Driver pushes hand-computed expectations; monitor pops one per clock and compares.
// Expectations follow DISP_SCAN_MUX_BLANK_EN if it is defined for the build.
module tb_disp_scan_mux;

    localparam logic [31:0] D0 = 32'h44332211;
    localparam logic [31:0] DA = 32'h4433AA11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_in = D0;
    logic        mode = 1'b0;
    logic [1:0]  sel_in = 2'd0;
    logic        hold = 1'b0;

    logic [7:0]  out4, out3;
    logic [3:0]  en4;
    logic [2:0]  en3;
    logic [1:0]  idx4, idx3;
    logic        vld4, vld3;

    typedef struct {
        logic [7:0]  out;
        logic [3:0]  en;
        logic [1:0]  idx;
        logic        vld;
        logic        d3;
        logic [95:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    disp_scan_mux #(.W(8), .N(4), .DWELL(3), .BLANK(2)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .mode     (mode),
        .sel_in   (sel_in),
        .hold     (hold),
        .out      (out4),
        .chan_en  (en4),
        .chan_idx (idx4),
        .valid    (vld4)
    );

    disp_scan_mux #(.W(8), .N(3), .DWELL(3), .BLANK(2)) u_dut3 (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in[23:0]),
        .mode     (mode),
        .sel_in   (sel_in),
        .hold     (hold),
        .out      (out3),
        .chan_en  (en3),
        .chan_idx (idx3),
        .valid    (vld3)
    );

    task automatic chk(input logic [95:0] tag, input logic [31:0] fld,
                       input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %0s.%0s got=%h want=%h at %0t", tag, fld, act, want, $time);
        end
    endtask

    // Drive inputs for the next edge and queue what that edge must produce.
    task automatic step(input logic r, input logic m, input logic [1:0] s, input logic h,
                        input logic [31:0] dat, input logic d3,
                        input logic [7:0] e_out, input logic [3:0] e_en,
                        input logic [1:0] e_idx, input logic e_vld, input logic [95:0] tag);
        exp_t e;
        @(posedge clk);
        #2;
        reset   = r;
        mode    = m;
        sel_in  = s;
        hold    = h;
        data_in = dat;
        e.out = e_out; e.en = e_en; e.idx = e_idx; e.vld = e_vld; e.d3 = d3; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic rst_step(input logic [95:0] tag);
        // Reset must win over manual select and hold.
        step(1'b1, 1'b1, 2'd2, 1'b1, D0, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0, tag);
    endtask

    // Monitor
    initial begin
        exp_t e;
        logic [7:0] a_out;
        logic [3:0] a_en;
        logic [1:0] a_idx;
        logic       a_vld;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e     = exp_q.pop_front();
                a_out = e.d3 ? out3 : out4;
                a_en  = e.d3 ? {1'b0, en3} : en4;
                a_idx = e.d3 ? idx3 : idx4;
                a_vld = e.d3 ? vld3 : vld4;
                chk(e.tag, "out", a_out, e.out);
                chk(e.tag, "en",  {4'h0, a_en}, {4'h0, e.en});
                chk(e.tag, "idx", {6'h0, a_idx}, {6'h0, e.idx});
                chk(e.tag, "vld", {7'h0, a_vld}, {7'h0, e.vld});
            end
        end
    end

    // Driver
    initial begin
        repeat (2) step(1'b1, 1'b0, 2'd0, 1'b0, D0, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0, "reset");
        rst_step("rst_ovr");

        // Auto scan through all channels and wrap
        repeat (3) step(0, 0, 0, 0, D0, 0, 8'h11, 4'b0001, 2'd0, 1, "scan_c0");
`ifdef DISP_SCAN_MUX_BLANK_EN
        repeat (2) step(0, 0, 0, 0, D0, 0, 8'h00, 4'b0000, 2'd0, 0, "scan_gap0");
`endif
        repeat (3) step(0, 0, 0, 0, D0, 0, 8'h22, 4'b0010, 2'd1, 1, "scan_c1");
`ifdef DISP_SCAN_MUX_BLANK_EN
        repeat (2) step(0, 0, 0, 0, D0, 0, 8'h00, 4'b0000, 2'd1, 0, "scan_gap1");
`endif
        repeat (3) step(0, 0, 0, 0, D0, 0, 8'h33, 4'b0100, 2'd2, 1, "scan_c2");
`ifdef DISP_SCAN_MUX_BLANK_EN
        repeat (2) step(0, 0, 0, 0, D0, 0, 8'h00, 4'b0000, 2'd2, 0, "scan_gap2");
`endif
        repeat (3) step(0, 0, 0, 0, D0, 0, 8'h44, 4'b1000, 2'd3, 1, "scan_c3");
`ifdef DISP_SCAN_MUX_BLANK_EN
        repeat (2) step(0, 0, 0, 0, D0, 0, 8'h00, 4'b0000, 2'd3, 0, "scan_gap3");
`endif
        step(0, 0, 0, 0, D0, 0, 8'h11, 4'b0001, 2'd0, 1, "scan_wrap");

        // Hold during channel 1: 1 + 5 held + 2 remaining cycles of 0x22
        rst_step("rst_hold");
        repeat (3) step(0, 0, 0, 0, D0, 0, 8'h11, 4'b0001, 2'd0, 1, "hold_c0");
`ifdef DISP_SCAN_MUX_BLANK_EN
        repeat (2) step(0, 0, 0, 0, D0, 0, 8'h00, 4'b0000, 2'd0, 0, "hold_gap0");
`endif
        step(0, 0, 0, 0, D0, 0, 8'h22, 4'b0010, 2'd1, 1, "hold_c1a");
        repeat (2) step(0, 0, 0, 1, D0, 0, 8'h22, 4'b0010, 2'd1, 1, "hold_on");
        step(0, 0, 0, 1, DA, 0, 8'hAA, 4'b0010, 2'd1, 1, "hold_trk");
        repeat (2) step(0, 0, 0, 1, D0, 0, 8'h22, 4'b0010, 2'd1, 1, "hold_on");
        repeat (2) step(0, 0, 0, 0, D0, 0, 8'h22, 4'b0010, 2'd1, 1, "hold_rem");
`ifdef DISP_SCAN_MUX_BLANK_EN
        repeat (2) step(0, 0, 0, 0, D0, 0, 8'h00, 4'b0000, 2'd1, 0, "hold_gap1");
`endif
        step(0, 0, 0, 0, D0, 0, 8'h33, 4'b0100, 2'd2, 1, "hold_adv");

        // Manual select on the N=3 instance; 2'b11 is the truncated sel_in=7
        rst_step("rst_man");
        step(0, 0, 0, 0, D0, 1, 8'h11, 4'b0001, 2'd0, 1, "man_auto0");
`ifdef DISP_SCAN_MUX_BLANK_EN
        repeat (2) step(0, 1, 2'd2, 0, D0, 1, 8'h00, 4'b0000, 2'd0, 0, "man_gap");
`endif
        step(0, 1, 2'd2, 0, D0, 1, 8'h33, 4'b0100, 2'd2, 1, "man_sel2");
        repeat (3) step(0, 1, 2'd3, 1, D0, 1, 8'h33, 4'b0100, 2'd2, 1, "man_clamp");
`ifdef DISP_SCAN_MUX_BLANK_EN
        step(0, 1, 2'd0, 0, D0, 1, 8'h00, 4'b0000, 2'd2, 0, "man_retgt");
        step(0, 1, 2'd1, 0, D0, 1, 8'h00, 4'b0000, 2'd2, 0, "man_retgt");
        step(0, 1, 2'd1, 0, D0, 1, 8'h22, 4'b0010, 2'd1, 1, "man_retgt");
`else
        step(0, 1, 2'd0, 0, D0, 1, 8'h11, 4'b0001, 2'd0, 1, "man_sel0");
        step(0, 1, 2'd1, 0, D0, 1, 8'h22, 4'b0010, 2'd1, 1, "man_sel1");
        step(0, 1, 2'd1, 0, D0, 1, 8'h22, 4'b0010, 2'd1, 1, "man_sel1");
`endif
        repeat (3) step(0, 0, 2'd1, 0, D0, 1, 8'h22, 4'b0010, 2'd1, 1, "man_resume");
`ifdef DISP_SCAN_MUX_BLANK_EN
        step(0, 0, 2'd1, 0, D0, 1, 8'h00, 4'b0000, 2'd1, 0, "man_rgap");
`else
        step(0, 0, 2'd1, 0, D0, 1, 8'h33, 4'b0100, 2'd2, 1, "man_radv");
`endif

        // Reset in the middle of channel 2, then release
        rst_step("rst_pre");
        repeat (3) step(0, 0, 0, 0, D0, 0, 8'h11, 4'b0001, 2'd0, 1, "mid_c0");
`ifdef DISP_SCAN_MUX_BLANK_EN
        repeat (2) step(0, 0, 0, 0, D0, 0, 8'h00, 4'b0000, 2'd0, 0, "mid_gap0");
`endif
        repeat (3) step(0, 0, 0, 0, D0, 0, 8'h22, 4'b0010, 2'd1, 1, "mid_c1");
`ifdef DISP_SCAN_MUX_BLANK_EN
        repeat (2) step(0, 0, 0, 0, D0, 0, 8'h00, 4'b0000, 2'd1, 0, "mid_gap1");
`endif
        repeat (2) step(0, 0, 0, 0, D0, 0, 8'h33, 4'b0100, 2'd2, 1, "mid_c2");
        rst_step("rst_mid");
        step(0, 0, 0, 0, D0, 0, 8'h11, 4'b0001, 2'd0, 1, "rst_rel");
`ifdef DISP_SCAN_MUX_BLANK_EN
        // Reset landing in the middle of a blank gap
        repeat (2) step(0, 0, 0, 0, D0, 0, 8'h11, 4'b0001, 2'd0, 1, "gap_c0");
        step(0, 0, 0, 0, D0, 0, 8'h00, 4'b0000, 2'd0, 0, "gap_mid");
        rst_step("rst_gap");
        step(0, 0, 0, 0, D0, 0, 8'h11, 4'b0001, 2'd0, 1, "gap_rel");
`endif

        // Let the monitor drain, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
